// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_pkg : shared encodings and FSM state type for the data-cache sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package mem_pkg;

    localparam logic [1:0] RW_LOAD  = 2'b01;
    localparam logic [1:0] RW_STORE = 2'b10;

    localparam logic [2:0] LEN_B  = 3'b000;
    localparam logic [2:0] LEN_H  = 3'b001;
    localparam logic [2:0] LEN_W  = 3'b010;
    localparam logic [2:0] LEN_BU = 3'b100;
    localparam logic [2:0] LEN_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Unlisted length codes behave as a full word.
    function automatic size_e len_size(input logic [2:0] len);
        case (len)
            LEN_B, LEN_BU: len_size = SZ_B;
            LEN_H, LEN_HU: len_size = SZ_H;
            default:       len_size = SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align : shifts a raw cache word by the byte offset and extends it     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module load_align
    import mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata_i,
    input  logic [1:0]    offset_i,
    input  logic [2:0]    len_i,
    output logic [DW-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = rdata_i[{offset_i, 3'b000} +: 8];
    assign w_half = rdata_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = rdata_i;
        case (len_i)
            LEN_B:   data_o = {{(DW-8){w_byte[7]}}, w_byte};
            LEN_BU:  data_o = {{(DW-8){1'b0}}, w_byte};
            LEN_H:   data_o = {{(DW-16){w_half[15]}}, w_half};
            LEN_HU:  data_o = {{(DW-16){1'b0}}, w_half};
            LEN_W:   data_o = rdata_i;
            default: data_o = rdata_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_ctrl : one load/store per instruction between MEM1 and D-cache  |
// | Optional macro MEM_ALIGN_CHECK_EN enables the misaligned-address trap.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   in_addr,
    input  logic [DW-1:0]   in_wdata,
    input  logic [1:0]      in_rw,
    input  logic [2:0]      in_len,
    input  logic [4:0]      in_rd,
    input  logic            in_wb,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic [4:0]      out_rd,
    output logic            out_wb,
    output logic            out_ale,
    output logic            dc_req,
    output logic            dc_wr,
    output logic [AW-1:0]   dc_addr,
    output logic [DW/8-1:0] dc_wstrb,
    output logic [DW-1:0]   dc_wdata,
    input  logic            dc_addr_ok,
    input  logic            dc_data_ok,
    input  logic [DW-1:0]   dc_rdata
);

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [1:0]        rw_q, rw_d;
    logic [2:0]        len_q, len_d;
    logic [4:0]        rd_q, rd_d;
    logic              wb_q, wb_d;
    logic              ale_q, ale_d;
    logic [DW-1:0]     data_q, data_d;

    logic              w_in_is_mem;
    logic              w_misaligned;
    logic [DW-1:0]     w_load_data;
    logic [DW/8-1:0]   w_strb;
    logic [DW-1:0]     w_wdata;
    logic              w_is_store;

    assign w_in_is_mem = (in_rw == RW_LOAD) || (in_rw == RW_STORE);
    assign w_is_store  = (rw_q == RW_STORE);

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = ((len_size(in_len) == SZ_H) && in_addr[0]) ||
                          ((len_size(in_len) == SZ_W) && (in_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    load_align #(.DW(DW)) u_load_align (
        .rdata_i  (dc_rdata),
        .offset_i (addr_q[1:0]),
        .len_i    (len_q),
        .data_o   (w_load_data)
    );

    // Low address bits only steer byte/half lanes; words always use all strobes.
    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = wdata_q;
        case (len_size(len_q))
            SZ_B: begin
                w_strb  = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            SZ_H: begin
                w_strb  = 4'b0011 << {addr_q[1], 1'b0};
                w_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = wdata_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= '0;
            len_q   <= '0;
            rd_q    <= '0;
            wb_q    <= 1'b0;
            ale_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            ale_q   <= ale_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        len_d   = len_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        ale_d   = ale_q;
        data_d  = data_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    rw_d    = in_rw;
                    len_d   = in_len;
                    rd_d    = in_rd;
                    wb_d    = in_wb;
                    ale_d   = 1'b0;
                    if (!w_in_is_mem || w_misaligned) begin
                        state_d = ST_HOLD;
                        data_d  = DW'(in_addr);
                        ale_d   = w_in_is_mem;
                    end else begin
                        state_d = ST_ADDR;
                        data_d  = '0;
                    end
                end
            end
            ST_ADDR: begin
                if (flush) begin
                    state_d = dc_addr_ok ? ST_DRAIN : ST_IDLE;
                end else if (dc_addr_ok) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (flush) begin
                    state_d = dc_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (dc_data_ok) begin
                    state_d = ST_HOLD;
                    if (rw_q == RW_LOAD) begin
                        data_d = w_load_data;
                    end
                end
            end
            // The cache still owes a response; swallow it before accepting again.
            ST_DRAIN: begin
                if (dc_data_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign out_valid = (state_q == ST_HOLD) && !flush;
    assign out_data  = data_q;
    assign out_rd    = rd_q;
    assign out_wb    = wb_q && !ale_q;
    assign out_ale   = ale_q;
    assign dc_req    = (state_q == ST_ADDR);
    assign dc_wr     = (state_q == ST_ADDR) && w_is_store;
    assign dc_addr   = {addr_q[AW-1:2], 2'b00};
    assign dc_wstrb  = w_is_store ? w_strb : '0;
    assign dc_wdata  = w_wdata;

endmodule
`default_nettype wire
